// File: rtl/alu_sequencer.sv
// alu_sequencer: runs one request through an external ALU and returns result and NZCV flags.
// Macro DECIMAL_MODE_EN enables decimal ADC/SBC, which take an extra ADJUST cycle.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_c,
  input  logic       req_v,
  input  logic       req_d,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [4:0] alu_ctrl,
  output logic       alu_addc,
  output logic       alu_daa,
  output logic       alu_dsa,
  input  logic [7:0] alu_sb,
  input  logic       alu_acr,
  input  logic       alu_avr,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_n,
  output logic       res_z,
  output logic       res_c,
  output logic       res_v
);
  typedef enum logic [1:0] {IDLE, EXEC, ADJUST, DONE} state_t;
  localparam logic [2:0] OP_ADC = 3'd0, OP_SBC = 3'd1, OP_AND = 3'd2, OP_ORA = 3'd3;
  localparam logic [2:0] OP_EOR = 3'd4, OP_ROR = 3'd6, OP_CMP = 3'd7;
  state_t state, state_nxt;
  logic [2:0] op;
  logic [7:0] a, b;
  logic c, v, dec, busy, accept, is_sum, use_acr, use_avr;
`ifdef DECIMAL_MODE_EN
  logic d;
  always_ff @(posedge clk) d <= rst ? 1'b0 : accept ? req_d : d;
  assign dec = d && (op == OP_ADC || op == OP_SBC);
`else
  logic unused_d;
  assign unused_d = req_d;
  assign dec = 1'b0;
`endif
  assign req_ready = state == IDLE;
  assign res_valid = state == DONE;
  assign accept = req_ready && req_valid;
  assign busy = state == EXEC || state == ADJUST;
  assign is_sum = op == OP_ADC || op == OP_SBC || op == OP_CMP;
  assign use_acr = !(op == OP_AND || op == OP_ORA || op == OP_EOR);
  assign use_avr = op == OP_ADC || op == OP_SBC;
  always_comb begin
    state_nxt = state == IDLE ? (req_valid ? EXEC : IDLE) :
                state == EXEC ? (dec ? ADJUST : DONE) :
                state == ADJUST ? DONE : (res_ready ? IDLE : DONE);
    alu_a = busy ? a : 8'h00;
    alu_b = !busy ? 8'h00 : (op == OP_SBC || op == OP_CMP) ? ~b : b;
    alu_ctrl = !busy ? 5'b00000 : is_sum ? 5'b00001 : op == OP_AND ? 5'b00010 :
               op == OP_ORA ? 5'b00100 : op == OP_EOR ? 5'b01000 : 5'b10000;
    alu_addc = busy && (op == OP_CMP || ((op == OP_ADC || op == OP_SBC || op == OP_ROR) && c));
    alu_daa = busy && dec && op == OP_ADC;
    alu_dsa = busy && dec && op == OP_SBC;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= 3'd0;
      a <= 8'h00;
      b <= 8'h00;
      c <= 1'b0;
      v <= 1'b0;
      res_data <= 8'h00;
      res_n <= 1'b0;
      res_z <= 1'b0;
      res_c <= 1'b0;
      res_v <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op <= req_op;
        a <= req_a;
        b <= req_b;
        c <= req_c;
        v <= req_v;
      end
      // CMP reports the operand but takes N/Z from the ALU difference; V is only taken from EXEC
      if (busy) begin
        res_data <= op == OP_CMP ? a : alu_sb;
        res_n <= alu_sb[7];
        res_z <= alu_sb == 8'h00;
        res_c <= use_acr ? alu_acr : c;
        if (state == EXEC) res_v <= use_avr ? alu_avr : v;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random operations against a behavioural ALU and result model.
module tb_alu_sequencer;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, res_ready = 1'b0;
  logic [2:0] req_op = '0;
  logic [7:0] req_a = '0, req_b = '0;
  logic req_c = 1'b0, req_v = 1'b0, req_d = 1'b0, req_ready, res_valid;
  logic [7:0] alu_a, alu_b, alu_sb, res_data;
  logic [4:0] alu_ctrl;
  logic alu_addc, alu_daa, alu_dsa, alu_acr, alu_avr, res_n, res_z, res_c, res_v;
  int compared = 0, mismatched = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_v(req_v), .req_d(req_d),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_addc(alu_addc),
    .alu_daa(alu_daa), .alu_dsa(alu_dsa), .alu_sb(alu_sb), .alu_acr(alu_acr),
    .alu_avr(alu_avr), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_n(res_n), .res_z(res_z), .res_c(res_c), .res_v(res_v)
  );

  always #5 clk = ~clk;

  function automatic int b2i(input logic [7:0] x);
    return x[7:4] * 10 + x[3:0];
  endfunction

  function automatic logic [7:0] i2b(input int x);
    return 8'((x / 10) * 16 + x % 10);
  endfunction

  // ALU: first active cycle gives the binary result, the following cycle the decimal adjust;
  // V is deliberately corrupted in the adjust cycle so only the EXEC value may be kept.
  logic adj;
  logic [8:0] sum9;
  logic [7:0] ovf8;
  int dv;
  always @(posedge clk) adj <= alu_ctrl != 5'd0;
  always_comb begin
    sum9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_addc};
    ovf8 = ~(alu_a ^ alu_b) & (alu_a ^ sum9[7:0]);
    dv = 0;
    alu_sb = 8'h00;
    alu_acr = 1'b0;
    alu_avr = 1'b0;
    if (alu_ctrl[0]) begin
      alu_sb = sum9[7:0];
      alu_acr = sum9[8];
      alu_avr = ovf8[7];
      if (adj && alu_daa) begin
        dv = b2i(alu_a) + b2i(alu_b) + int'(alu_addc);
        alu_sb = i2b(dv % 100);
        alu_acr = dv > 99;
        alu_avr = ~ovf8[7];
      end
      if (adj && alu_dsa) begin
        dv = b2i(alu_a) - b2i(~alu_b) - 1 + int'(alu_addc);
        alu_sb = i2b((dv + 100) % 100);
        alu_acr = dv >= 0;
        alu_avr = ~ovf8[7];
      end
    end else if (alu_ctrl[1]) alu_sb = alu_a & alu_b;
    else if (alu_ctrl[2]) alu_sb = alu_a | alu_b;
    else if (alu_ctrl[3]) alu_sb = alu_a ^ alu_b;
    else if (alu_ctrl[4]) begin
      alu_sb = {alu_addc, alu_a[7:1]};
      alu_acr = alu_a[0];
    end
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s %s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  // Expected result from the instruction semantics in plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic c, input logic v, input logic dm, output logic [7:0] rd,
                                output logic [3:0] nzcv);
    int ia, ib, ci, sa, sb, s;
    logic [7:0] t;
    logic rn, rz, rc, rv;
    ia = int'(a); ib = int'(b); ci = int'(c);
    sa = int'($signed(a)); sb = int'($signed(b));
    rd = 8'h00; rc = c; rv = v; t = 8'h00;
    case (op)
      3'd0: begin
        s = ia + ib + ci; rd = 8'(s); rc = s > 255;
        rv = (sa + sb + ci > 127) || (sa + sb + ci < -128);
        if (dm) begin
          s = b2i(a) + b2i(b) + ci; rd = i2b(s % 100); rc = s > 99;
        end
      end
      3'd1: begin
        s = ia - ib - 1 + ci; rd = 8'(s); rc = s >= 0;
        rv = (sa - sb - 1 + ci > 127) || (sa - sb - 1 + ci < -128);
        if (dm) begin
          s = b2i(a) - b2i(b) - 1 + ci; rd = i2b((s + 100) % 100); rc = s >= 0;
        end
      end
      3'd2: rd = a & b;
      3'd3: rd = a | b;
      3'd4: rd = a ^ b;
      3'd5: begin rd = a >> 1; rc = a[0]; end
      3'd6: begin rd = (a >> 1) | (c ? 8'h80 : 8'h00); rc = a[0]; end
      default: begin s = ia - ib; t = 8'(s); rd = a; rc = s >= 0; end
    endcase
    rn = op == 3'd7 ? t[7] : rd[7];
    rz = op == 3'd7 ? t == 8'h00 : rd == 8'h00;
    nzcv = {rn, rz, rc, rv};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic v, input logic d, input int hold, input string tag);
    logic [7:0] rd, eb;
    logic [3:0] nzcv;
    logic [12:0] snap;
    logic dm, eaddc;
    logic [4:0] ectrl;
    int act, daa_n, dsa_n;
    dm = 1'b0;
`ifdef DECIMAL_MODE_EN
    dm = d && op < 3'd2;
`endif
    model(op, a, b, c, v, dm, rd, nzcv);
    ectrl = op == 3'd0 || op == 3'd1 || op == 3'd7 ? 5'b00001 : op == 3'd2 ? 5'b00010 :
            op == 3'd3 ? 5'b00100 : op == 3'd4 ? 5'b01000 : 5'b10000;
    eb = op == 3'd1 || op == 3'd7 ? ~b : b;
    eaddc = op == 3'd7 ? 1'b1 : (op == 3'd0 || op == 3'd1 || op == 3'd6) ? c : 1'b0;
    chk(tag, "req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_c = c; req_v = v; req_d = d;
    @(negedge clk);
    req_valid = 1'b0;
    act = 0; daa_n = 0; dsa_n = 0;
    while (!res_valid && act < 8) begin
      chk(tag, "alu_drive", {alu_ctrl, alu_a, alu_b, alu_addc, req_ready},
          {ectrl, a, eb, eaddc, 1'b0});
      daa_n += int'(alu_daa);
      dsa_n += int'(alu_dsa);
      act++;
      @(negedge clk);
    end
    chk(tag, "active_cycles", act, dm ? 2 : 1);
    chk(tag, "daa_cycles", daa_n, dm && op == 3'd0 ? 2 : 0);
    chk(tag, "dsa_cycles", dsa_n, dm && op == 3'd1 ? 2 : 0);
    chk(tag, "res_valid", res_valid, 1);
    chk(tag, "res_data", res_data, rd);
    chk(tag, "res_nzcv", {res_n, res_z, res_c, res_v}, nzcv);
    chk(tag, "done_drive", {alu_ctrl, alu_daa, alu_dsa}, 0);
    snap = {res_data, res_n, res_z, res_c, res_v, res_valid};
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 3'($urandom); req_a = 8'($urandom);
      @(negedge clk);
      chk(tag, "hold_stable", {res_data, res_n, res_z, res_c, res_v, res_valid}, snap);
      chk(tag, "hold_not_ready", req_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk(tag, "release_idle", {req_ready, res_valid}, 2'b10);
    req_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset", "ready_valid", {req_ready, res_valid}, 2'b10);
    chk("reset", "res", {res_data, res_n, res_z, res_c, res_v}, 0);
    chk("reset", "alu", {alu_a, alu_b, alu_ctrl, alu_addc, alu_daa, alu_dsa}, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 0, "adc_50_50");
`ifdef DECIMAL_MODE_EN
    run_op(3'd1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 0, "sbc_dec");
`else
    run_op(3'd0, 8'h09, 8'h01, 1'b0, 1'b0, 1'b1, 0, "adc_d_ignored");
`endif
    run_op(3'd7, 8'h10, 8'h10, 1'b0, 1'b1, 1'b0, 0, "cmp_eq");
    run_op(3'd6, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 0, "ror");
    run_op(3'd5, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 0, "lsr");
    run_op(3'd2, 8'hC3, 8'h5A, 1'b1, 1'b1, 1'b0, 3, "and_hold");
    req_valid = 1'b1; req_op = 3'd0; req_a = 8'h15; req_b = 8'h27; req_c = 1'b0; req_d = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_exec", "in_exec", {req_ready, alu_ctrl}, 6'b000001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exec", "aborted", {req_ready, res_valid, alu_ctrl}, 7'b1000000);
    @(negedge clk);
    chk("rst_exec", "no_result", {req_ready, res_valid}, 2'b10);
    for (int n = 0; n < 80; n++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      logic d;
      op = 3'($urandom_range(0, 7));
      d = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      if (d && op < 3'd2) begin
        a = i2b($urandom_range(0, 99));
        b = i2b($urandom_range(0, 99));
      end
      run_op(op, a, b, 1'($urandom), 1'($urandom), d, $urandom_range(0, 3), "random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have no parameters; the datapath is fixed at 8 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 req_op  input  3  000 ADC, 001 SBC, 010 AND, 011 ORA, 100 EOR, 101 LSR, 110 ROR, 111 CMP.
REQ-007 req_a, req_b  input  8 each  accumulator and memory operands.
REQ-008 req_c, req_v, req_d  input  1 each  incoming carry, overflow and decimal flags.
REQ-009 alu_a, alu_b  output  8 each  ALU operand drive.
REQ-010 alu_ctrl  output  5  one-hot ALU select: bit0 SUMS, bit1 ANDS, bit2 ORS, bit3 EORS, bit4 SRS.
REQ-011 alu_addc, alu_daa, alu_dsa  output  1 each  ALU carry-in and decimal add/subtract enables.
REQ-012 alu_sb  input  8  adjusted ALU result (decimal-adjust output); alu_acr, alu_avr  input  1 each  ALU carry and overflow.
REQ-013 res_valid  output  1; res_ready  input  1  result handshake.
REQ-014 res_data  output  8; res_n, res_z, res_c, res_v  output  1 each  result and flags.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, ADJUST, DONE; req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: on req_valid=1, latch all req_* inputs and go to EXEC; otherwise stay.
REQ-017 EXEC: drive ALU from latched operands for exactly one cycle; at its closing edge capture alu_sb, alu_acr, alu_avr; go to ADJUST for a decimal op, else DONE.
REQ-018 Op mapping: ADC SUMS, b=req_b, addc=req_c; SBC SUMS, b=~req_b, addc=req_c; CMP SUMS, b=~req_b, addc=1; AND/ORA/EOR ANDS/ORS/EORS, addc=0; LSR SRS, addc=0; ROR SRS, addc=req_c; alu_a=req_a in all cases.
REQ-019 Decimal op: ADC or SBC with latched req_d=1 (never CMP); alu_daa=1 for ADC, alu_dsa=1 for SBC during EXEC and ADJUST.
REQ-020 ADJUST: keep identical ALU drive one further cycle; at its closing edge recapture alu_sb and alu_acr; keep V from EXEC; go to DONE.
REQ-021 alu_ctrl, alu_daa, alu_dsa SHALL be 0 in IDLE and DONE; alu_ctrl exactly one-hot in EXEC/ADJUST.
REQ-022 DONE: res_valid=1; res_* held stable until res_ready=1, then IDLE; no request accepted in the same cycle as result release.
REQ-023 Flags: res_data = captured result (CMP: res_data = latched req_a); N = result bit7, Z = result==0 (CMP: from ALU difference); C = alu_acr for ADC/SBC/CMP/LSR/ROR, else req_c; V = alu_avr for ADC/SBC, else req_v.
REQ-024 Latency: accept edge E0; res_valid high after E1 (binary) or E2 (decimal).

Reset
REQ-025 rst=1 SHALL force IDLE on the next edge from any state, aborting an in-flight operation without producing a result.
REQ-026 Reset values: req_ready=1, res_valid=0, res_data=0, all res flags 0, alu_a=alu_b=0, alu_ctrl=0, alu_addc=alu_daa=alu_dsa=0.

Configuration
REQ-027 Macro DECIMAL_MODE_EN: defined -> decimal ops and the ADJUST state per REQ-019/020; undefined -> req_d ignored, alu_daa/alu_dsa tied 0, ADJUST unreachable, all ops binary with latency per REQ-024 binary.

Verification
REQ-028 ADC a=50 b=50 c=0 d=0 -> res_data=A0, N=1 Z=0 C=0 V=1, res_valid after E1.
REQ-029 SBC a=00 b=01 c=1 d=1 (macro on) -> res_data=99, C=0, alu_dsa=1 for two cycles, res_valid after E2; macro off, ADC a=09 b=01 d=1 -> 0A, alu_daa=0.
REQ-030 CMP a=10 b=10 -> res_data=10, Z=1 C=1 N=0, V=req_v.
REQ-031 ROR a=01 c=1 -> res_data=80, C=1, N=1; LSR a=01 -> 00, C=1, Z=1.
REQ-032 res_ready=0 for 3 cycles in DONE -> res_* stable, req_ready=0, req_valid ignored; release -> IDLE next cycle.
REQ-033 rst=1 during EXEC of a decimal ADC -> next cycle IDLE, res_valid=0, alu_ctrl=0, req_ready=1.
